keypoint_gradient_fetch: RTL and testbench

- Stage directly downstream of keypoint detection/filtering.
- After detection completes, walks both keypoint lists (list 0 = DoG pair 0, list 1 = DoG pair 1).
- For each keypoint, reads the 3 neighbouring rows of the matching blurred image and emits {layer, row, col, dx, dy} over a valid/ready stream.
- The stream feeds orientation assignment.

---
 rtl/sift_pkg.sv | 53 +++++
 rtl/keypoint_gradient_fetch_if.sv | 22 ++
 rtl/row_pixel_mux.sv | 24 ++
 rtl/keypoint_gradient_fetch.sv | 242 ++++++++++++++++++++++++
 tb/tb_keypoint_gradient_fetch.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sift_pkg.sv
// Shared constants, types and FSM encoding for the SIFT keypoint pipeline stages.
// Keypoint entries are packed {row[18:10], col[9:0]}; pixel c of a row word is bits [PIX_W*c +: PIX_W].
package sift_pkg;

    localparam int IMG_W      = 640;
    localparam int IMG_H      = 480;
    localparam int PIX_W      = 8;
    localparam int KP_AW      = 11;

    localparam int ROW_W      = 9;
    localparam int COL_W      = 10;
    localparam int KP_W       = ROW_W + COL_W;
    localparam int KP_ROW_LSB = 10;
    localparam int KP_COL_LSB = 0;
    localparam int ROW_WORD_W = IMG_W * PIX_W;

    typedef logic [ROW_W-1:0]        row_t;
    typedef logic [COL_W-1:0]        col_t;
    typedef logic [PIX_W-1:0]        pix_t;
    typedef logic signed [PIX_W:0]   grad_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_KLAT = 3'd1,
        S_TOP  = 3'd2,
        S_MID  = 3'd3,
        S_BOT  = 3'd4,
        S_OUT  = 3'd5,
        S_DONE = 3'd6
    } state_e;

    typedef struct packed {
        logic  layer;
        row_t  row;
        col_t  col;
        grad_t dx;
        grad_t dy;
    } grad_rec_t;

    function automatic row_t kp_row(input logic [KP_W-1:0] entry);
        return entry[KP_ROW_LSB +: ROW_W];
    endfunction

    function automatic col_t kp_col(input logic [KP_W-1:0] entry);
        return entry[KP_COL_LSB +: COL_W];
    endfunction

    // Pixels are unsigned, so zero-extend before subtracting; the result always fits in 9 bits.
    function automatic grad_t pix_diff(input pix_t a, input pix_t b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

endpackage

// File: rtl/keypoint_gradient_fetch_if.sv
// Gradient record stream toward orientation assignment: valid/ready plus the record fields.
interface keypoint_gradient_fetch_if;

    logic              out_valid;
    logic              out_ready;
    logic              out_layer;
    sift_pkg::row_t    out_row;
    sift_pkg::col_t    out_col;
    sift_pkg::grad_t   out_dx;
    sift_pkg::grad_t   out_dy;

    modport master (
        output out_valid, out_layer, out_row, out_col, out_dx, out_dy,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_layer, out_row, out_col, out_dx, out_dy,
        output out_ready
    );

endinterface

// File: rtl/row_pixel_mux.sv
// Picks one pixel out of a full image row word; out-of-range columns replicate the nearest edge pixel.
module row_pixel_mux
    import sift_pkg::*;
(
    input  logic [ROW_WORD_W-1:0] row_i,
    input  logic signed [COL_W:0] col_i,
    output pix_t                  pix_o
);

    localparam logic signed [COL_W:0] COL_MAX = (COL_W + 1)'(IMG_W - 1);

    col_t sel;

    always_comb begin
        sel = col_i[COL_W-1:0];
        if (col_i[COL_W]) begin
            sel = '0;
        end else if (col_i > COL_MAX) begin
            sel = COL_MAX[COL_W-1:0];
        end
        pix_o = row_i[int'(sel) * PIX_W +: PIX_W];
    end

endmodule

// File: rtl/keypoint_gradient_fetch.sv
// Walks both keypoint lists after detection and emits {layer, row, col, dx, dy} per keypoint,
// reading the three neighbouring image rows (edge-clamped) from the matching blurred image.
module keypoint_gradient_fetch
    import sift_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [KP_AW-1:0]      kp_0_num,
    input  logic [KP_AW-1:0]      kp_1_num,
    output logic [KP_AW-1:0]      kp_0_addr,
    input  logic [KP_W-1:0]       kp_0_dout,
    output logic [KP_AW-1:0]      kp_1_addr,
    input  logic [KP_W-1:0]       kp_1_dout,
    output row_t                  img_0_addr,
    input  logic [ROW_WORD_W-1:0] img_0_dout,
    output row_t                  img_1_addr,
    input  logic [ROW_WORD_W-1:0] img_1_dout,
    keypoint_gradient_fetch_if.master out_if,
    output logic                  busy,
    output logic                  done
);

    localparam logic signed [COL_W:0] COL_ONE = {{COL_W{1'b0}}, 1'b1};
    localparam row_t                  ROW_MAX = row_t'(IMG_H - 1);

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             layer_q, layer_d;
    logic [KP_AW-1:0] idx_q, idx_d;
    logic [KP_AW-1:0] num0_q, num0_d;
    logic [KP_AW-1:0] num1_q, num1_d;
    logic [KP_AW-1:0] kp0_addr_q, kp0_addr_d;
    logic [KP_AW-1:0] kp1_addr_q, kp1_addr_d;
    row_t             img0_addr_q, img0_addr_d;
    row_t             img1_addr_q, img1_addr_d;
    row_t             row_q, row_d;
    col_t             col_q, col_d;
    pix_t             top_q, top_d;
    pix_t             left_q, left_d;
    pix_t             right_q, right_d;
    logic             out_valid_q, out_valid_d;
    grad_rec_t        rec_q, rec_d;

    logic [KP_W-1:0]       kp_act;
    logic [ROW_WORD_W-1:0] img_act;
    logic [KP_AW-1:0]      num_act;
    logic [KP_AW-1:0]      idx_inc;
    logic                  more_in_list;
    row_t                  kp_r;
    logic signed [COL_W:0] col_c, col_l, col_r;
    pix_t                  pix_c, pix_l, pix_r;
    logic                  img_we;
    row_t                  img_nxt;

    // Every read and every neighbour mux follows the list currently being walked.
    assign kp_act  = layer_q ? kp_1_dout  : kp_0_dout;
    assign img_act = layer_q ? img_1_dout : img_0_dout;
    assign num_act = layer_q ? num1_q     : num0_q;

    assign idx_inc      = idx_q + 1'b1;
    assign more_in_list = ({1'b0, idx_q} + 1'b1) < {1'b0, num_act};
    assign kp_r         = kp_row(kp_act);

    assign col_c = $signed({1'b0, col_q});
    assign col_l = col_c - COL_ONE;
    assign col_r = col_c + COL_ONE;

    row_pixel_mux u_pix_c (.row_i(img_act), .col_i(col_c), .pix_o(pix_c));
    row_pixel_mux u_pix_l (.row_i(img_act), .col_i(col_l), .pix_o(pix_l));
    row_pixel_mux u_pix_r (.row_i(img_act), .col_i(col_r), .pix_o(pix_r));

    always_comb begin
        // NOTE: every variable gets its hold value first, so no branch can leave one unassigned and infer a latch.
        state_d     = state_q;
        busy_d      = busy_q;
        layer_d     = layer_q;
        idx_d       = idx_q;
        num0_d      = num0_q;
        num1_d      = num1_q;
        kp0_addr_d  = kp0_addr_q;
        kp1_addr_d  = kp1_addr_q;
        img0_addr_d = img0_addr_q;
        img1_addr_d = img1_addr_q;
        row_d       = row_q;
        col_d       = col_q;
        top_d       = top_q;
        left_d      = left_q;
        right_d     = right_q;
        out_valid_d = out_valid_q;
        rec_d       = rec_q;
        img_we      = 1'b0;
        img_nxt     = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    num0_d = kp_0_num;
                    num1_d = kp_1_num;
                    busy_d = 1'b1;
                    idx_d  = '0;
                    if (kp_0_num != '0) begin
                        layer_d    = 1'b0;
                        kp0_addr_d = '0;
                        state_d    = S_KLAT;
                    end else if (kp_1_num != '0) begin
                        layer_d    = 1'b1;
                        kp1_addr_d = '0;
                        state_d    = S_KLAT;
                    end else begin
                        layer_d = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_KLAT: begin
                row_d   = kp_r;
                col_d   = kp_col(kp_act);
                img_we  = 1'b1;
                img_nxt = (kp_r == '0) ? '0 : kp_r - 1'b1;
                state_d = S_TOP;
            end
            S_TOP: begin
                top_d   = pix_c;
                img_we  = 1'b1;
                img_nxt = row_q;
                state_d = S_MID;
            end
            S_MID: begin
                left_d  = pix_l;
                right_d = pix_r;
                img_we  = 1'b1;
                img_nxt = (row_q >= ROW_MAX) ? ROW_MAX : row_q + 1'b1;
                state_d = S_BOT;
            end
            S_BOT: begin
                rec_d.layer = layer_q;
                rec_d.row   = row_q;
                rec_d.col   = col_q;
                rec_d.dx    = pix_diff(right_q, left_q);
                rec_d.dy    = pix_diff(pix_c, top_q);
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_if.out_ready) begin
                    out_valid_d = 1'b0;
                    idx_d       = idx_inc;
                    if (more_in_list) begin
                        if (layer_q) kp1_addr_d = idx_inc;
                        else         kp0_addr_d = idx_inc;
                        state_d = S_KLAT;
                    end else if (!layer_q && (num1_q != '0)) begin
                        layer_d    = 1'b1;
                        idx_d      = '0;
                        kp1_addr_d = '0;
                        state_d    = S_KLAT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy_d      = 1'b0;
                idx_d       = '0;
                kp0_addr_d  = '0;
                kp1_addr_d  = '0;
                img0_addr_d = '0;
                img1_addr_d = '0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The inactive list's image address is left untouched.
        if (img_we) begin
            if (layer_q) img1_addr_d = img_nxt;
            else         img0_addr_d = img_nxt;
        end

        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            layer_q     <= 1'b0;
            idx_q       <= '0;
            num0_q      <= '0;
            num1_q      <= '0;
            kp0_addr_q  <= '0;
            kp1_addr_q  <= '0;
            img0_addr_q <= '0;
            img1_addr_q <= '0;
            row_q       <= '0;
            col_q       <= '0;
            top_q       <= '0;
            left_q      <= '0;
            right_q     <= '0;
            out_valid_q <= 1'b0;
            rec_q       <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            layer_q     <= layer_d;
            idx_q       <= idx_d;
            num0_q      <= num0_d;
            num1_q      <= num1_d;
            kp0_addr_q  <= kp0_addr_d;
            kp1_addr_q  <= kp1_addr_d;
            img0_addr_q <= img0_addr_d;
            img1_addr_q <= img1_addr_d;
            row_q       <= row_d;
            col_q       <= col_d;
            top_q       <= top_d;
            left_q      <= left_d;
            right_q     <= right_d;
            out_valid_q <= out_valid_d;
            rec_q       <= rec_d;
        end
    end

    assign kp_0_addr  = kp0_addr_q;
    assign kp_1_addr  = kp1_addr_q;
    assign img_0_addr = img0_addr_q;
    assign img_1_addr = img1_addr_q;
    assign busy       = busy_q;
    assign done       = done_q;

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_layer = rec_q.layer;
    assign out_if.out_row   = rec_q.row;
    assign out_if.out_col   = rec_q.col;
    assign out_if.out_dx    = rec_q.dx;
    assign out_if.out_dy    = rec_q.dy;

endmodule

// File: tb/tb_keypoint_gradient_fetch.sv
// Directed bench for keypoint_gradient_fetch: single-keypoint vector table plus multi-record,
// back-pressure and mid-record reset sequences. Image 0 is I(r,c)=(r+c)&255, image 1 is (r+2c)&255.
module tb_keypoint_gradient_fetch;
    import sift_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic [KP_AW-1:0]      kp_0_num = '0;
    logic [KP_AW-1:0]      kp_1_num = '0;
    logic [KP_AW-1:0]      kp_0_addr, kp_1_addr;
    logic [KP_W-1:0]       kp_0_dout, kp_1_dout;
    row_t                  img_0_addr, img_1_addr;
    logic [ROW_WORD_W-1:0] img_0_dout, img_1_dout;
    logic                  busy, done;

    logic [KP_W-1:0] kp0_mem [2048];
    logic [KP_W-1:0] kp1_mem [2048];

    keypoint_gradient_fetch_if sif ();

    keypoint_gradient_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .kp_0_num   (kp_0_num),
        .kp_1_num   (kp_1_num),
        .kp_0_addr  (kp_0_addr),
        .kp_0_dout  (kp_0_dout),
        .kp_1_addr  (kp_1_addr),
        .kp_1_dout  (kp_1_dout),
        .img_0_addr (img_0_addr),
        .img_0_dout (img_0_dout),
        .img_1_addr (img_1_addr),
        .img_1_dout (img_1_dout),
        .out_if     (sif),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [ROW_WORD_W-1:0] img_row(input logic layer, input row_t r);
        logic [ROW_WORD_W-1:0] w;
        w = '0;
        for (int c = 0; c < IMG_W; c++) begin
            w[c*PIX_W +: PIX_W] = layer ? pix_t'(int'(r) + 2*c) : pix_t'(int'(r) + c);
        end
        return w;
    endfunction

    // The SRAM's address register is the DUT's registered address, so dout follows it within the cycle.
    assign kp_0_dout = kp0_mem[kp_0_addr];
    assign kp_1_dout = kp1_mem[kp_1_addr];
    always_comb img_0_dout = img_row(1'b0, img_0_addr);
    always_comb img_1_dout = img_row(1'b1, img_1_addr);

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [KP_W-1:0] kp_entry(input int r, input int c);
        return {row_t'(r), col_t'(c)};
    endfunction

    typedef struct {
        string name;
        bit    layer;
        int    row;
        int    col;
        int    a0, a1, a2;
        int    dx, dy;
    } vec_t;

    function automatic vec_t mk_vec(input string name, input bit layer, input int row, input int col,
                                    input int a0, input int a1, input int a2, input int dx, input int dy);
        vec_t v;
        v.name = name; v.layer = layer; v.row = row; v.col = col;
        v.a0 = a0; v.a1 = a1; v.a2 = a2; v.dx = dx; v.dy = dy;
        return v;
    endfunction

    vec_t vecs [7];

    task automatic check_rec(input string name, input bit layer, input int row, input int col,
                             input int dx, input int dy);
        check({name, ".valid"}, sif.out_valid, 1);
        check({name, ".layer"}, sif.out_layer, layer);
        check({name, ".row"},   sif.out_row,   row);
        check({name, ".col"},   sif.out_col,   col);
        check({name, ".dx"},    sif.out_dx,    dx);
        check({name, ".dy"},    sif.out_dy,    dy);
    endtask

    // One keypoint in one list, out_ready held high; the bench is at a negedge in S_IDLE on entry.
    task automatic run_single(input vec_t v);
        if (!v.layer) begin
            kp0_mem[0] = kp_entry(v.row, v.col);
            kp_0_num = 1; kp_1_num = 0;
        end else begin
            kp1_mem[0] = kp_entry(v.row, v.col);
            kp_0_num = 0; kp_1_num = 1;
        end
        sif.out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({v.name, ".busy"}, busy, 1);
        @(negedge clk);
        check({v.name, ".a0"}, v.layer ? img_1_addr : img_0_addr, v.a0);
        @(negedge clk);
        check({v.name, ".a1"}, v.layer ? img_1_addr : img_0_addr, v.a1);
        @(negedge clk);
        check({v.name, ".a2"}, v.layer ? img_1_addr : img_0_addr, v.a2);
        check({v.name, ".idle_addr"}, v.layer ? img_0_addr : img_1_addr, 0);
        check({v.name, ".early_valid"}, sif.out_valid, 0);
        @(negedge clk);
        check_rec(v.name, v.layer, v.row, v.col, v.dx, v.dy);
        @(negedge clk);
        check({v.name, ".done"}, done, 1);
        check({v.name, ".valid_drop"}, sif.out_valid, 0);
        @(negedge clk);
        check({v.name, ".done_once"}, done, 0);
        check({v.name, ".busy_end"}, busy, 0);
    endtask

    initial begin
        sif.out_ready = 1'b0;
        vecs[0] = mk_vec("l0_mid",    1'b0, 10,  20,  9,   10,  11,  2,    2);
        vecs[1] = mk_vec("l0_r0c639", 1'b0, 0,   639, 0,   0,   1,   1,    1);
        vecs[2] = mk_vec("l0_wrap",   1'b0, 250, 6,   249, 250, 251, -254, -254);
        vecs[3] = mk_vec("l0_r479c0", 1'b0, 479, 0,   478, 479, 479, 1,    1);
        vecs[4] = mk_vec("l1_mid",    1'b1, 10,  20,  9,   10,  11,  4,    2);
        vecs[5] = mk_vec("l1_corner", 1'b1, 479, 639, 478, 479, 479, 2,    1);
        vecs[6] = mk_vec("l1_origin", 1'b1, 0,   0,   0,   0,   1,   2,    1);

        repeat (2) @(negedge clk);
        check("rst.valid", sif.out_valid, 0);
        check("rst.busy",  busy, 0);
        check("rst.done",  done, 0);
        check("rst.kp0",   kp_0_addr, 0);
        check("rst.img0",  img_0_addr, 0);
        check("rst.dx",    sif.out_dx, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_single(vecs[i]);
            @(negedge clk);
        end

        // Both lists empty; start stays high into the done cycle and must be ignored there.
        kp_0_num = 0; kp_1_num = 0;
        start = 1'b1;
        @(negedge clk);
        check("empty.done", done, 1);
        check("empty.busy", busy, 1);
        check("empty.valid", sif.out_valid, 0);
        @(negedge clk);
        start = 1'b0;
        check("empty.done_once", done, 0);
        check("empty.busy_end", busy, 0);
        @(negedge clk);
        check("empty.restart_ignored", busy, 0);

        // Two records from list 0 then one from list 1, back to back.
        kp0_mem[0] = kp_entry(10, 20);
        kp0_mem[1] = kp_entry(100, 200);
        kp1_mem[0] = kp_entry(5, 7);
        kp_0_num = 2; kp_1_num = 1;
        sif.out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 1; t <= 16; t++) begin
            if (t == 5)  check_rec("multi.r0", 1'b0, 10, 20, 2, 2);
            if (t == 6)  check("multi.kp0_next", kp_0_addr, 1);
            if (t == 9)  check("multi.gap", sif.out_valid, 0);
            if (t == 10) check_rec("multi.r1", 1'b0, 100, 200, 2, 2);
            if (t == 11) check("multi.img1_still", img_1_addr, 0);
            if (t == 12) check("multi.img1_a0", img_1_addr, 4);
            if (t == 13) check("multi.img1_a1", img_1_addr, 5);
            if (t == 13) check("multi.img0_hold", img_0_addr, 101);
            if (t == 14) check("multi.img1_a2", img_1_addr, 6);
            if (t == 14) check("multi.kp1_addr", kp_1_addr, 0);
            if (t == 15) check_rec("multi.r2", 1'b1, 5, 7, 4, 2);
            if (t == 16) check("multi.done", done, 1);
            @(negedge clk);
        end
        check("multi.busy_end", busy, 0);
        @(negedge clk);

        // Back-pressure: out_ready low for 7 cycles, with a stray start that must be ignored.
        kp0_mem[0] = kp_entry(10, 20);
        kp0_mem[1] = kp_entry(0, 639);
        kp_0_num = 2; kp_1_num = 0;
        sif.out_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            check_rec($sformatf("stall.c%0d", i), 1'b0, 10, 20, 2, 2);
            check($sformatf("stall.kp0_c%0d", i), kp_0_addr, 0);
            start = (i == 2);
            @(negedge clk);
        end
        start = 1'b0;
        sif.out_ready = 1'b1;
        check("stall.kp0_at_hs", kp_0_addr, 0);
        @(negedge clk);
        check("stall.kp0_after_hs", kp_0_addr, 1);
        check("stall.valid_drop", sif.out_valid, 0);
        repeat (4) @(negedge clk);
        check_rec("stall.r1", 1'b0, 0, 639, 1, 1);
        @(negedge clk);
        check("stall.done", done, 1);
        @(negedge clk);

        // Reset asserted while the record is in S_MID, then a clean rerun.
        kp0_mem[0] = kp_entry(10, 20);
        kp_0_num = 1; kp_1_num = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort.valid", sif.out_valid, 0);
        check("abort.busy",  busy, 0);
        check("abort.done",  done, 0);
        check("abort.img0",  img_0_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_single(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
